// File: rtl/spi_sample_slave.sv
// SPI sample slave: buffers parallel samples in a FIFO and streams them to an SPI master
// via a command protocol (READ 0x03, STAT 0x05, CLR 0x01), with a level-threshold interrupt.
module spi_sample_slave #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 8,
    parameter int IRQ_THRESH = 4,
    parameter int LW         = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [1:0]        mode,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    input  logic              spi_csb,
    input  logic              spi_sck,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic [LW-1:0]     level,
    output logic              irq,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_READ, S_STAT, S_CLR, S_DUMMY} state_t;

    state_t            state_q, state_d;
    logic              csb_meta_q, csb_meta_d, csb_sync_q, csb_sync_d, csb_prev_q, csb_prev_d;
    logic              sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
    logic              sdi_meta_q, sdi_meta_d, sdi_sync_q, sdi_sync_d;
    logic [1:0]        mode_q, mode_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [6:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              sdo_q, sdo_d, sdo_oe_q, sdo_oe_d;
    logic              reload_q, reload_d, pop_pend_q, pop_pend_d, peek_empty_q, peek_empty_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d, irq_q, irq_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              full, empty, push, pop, ovf_set, unf_set, flag_clr;
    logic              sck_rise, sck_fall, sample_edge, shift_edge, csb_fall, csb_rise;
    logic [DATA_W-1:0] head;
    logic [7:0]        cmd_byte, status;

    assign full        = (level_q == LW'(DEPTH));
    assign empty       = (level_q == '0);
    assign head        = mem_q[rd_ptr_q];
    assign sck_rise    = sck_sync_q & ~sck_prev_q;
    assign sck_fall    = ~sck_sync_q & sck_prev_q;
    assign csb_fall    = csb_prev_q & ~csb_sync_q;
    assign csb_rise    = ~csb_prev_q & csb_sync_q;
    // mode_q = {CPOL, CPHA}; CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge
    assign sample_edge = (mode_q[1] ^ mode_q[0]) ? sck_fall : sck_rise;
    assign shift_edge  = (mode_q[1] ^ mode_q[0]) ? sck_rise : sck_fall;
    assign cmd_byte    = {cmd_q, sdi_sync_q};
    assign status      = {overflow_q, underflow_q, irq_q, 5'(level_q)};

    always_comb begin
        state_d      = state_q;
        csb_meta_d   = spi_csb;
        csb_sync_d   = csb_meta_q;
        csb_prev_d   = csb_sync_q;
        sck_meta_d   = spi_sck;
        sck_sync_d   = sck_meta_q;
        sck_prev_d   = sck_sync_q;
        sdi_meta_d   = spi_sdi;
        sdi_sync_d   = sdi_meta_q;
        mode_d       = mode_q;
        bit_cnt_d    = bit_cnt_q;
        cmd_d        = cmd_q;
        tx_d         = tx_q;
        sdo_d        = sdo_q;
        sdo_oe_d     = sdo_oe_q;
        reload_d     = reload_q;
        pop_pend_d   = pop_pend_q;
        peek_empty_d = peek_empty_q;
        pop          = 1'b0;
        unf_set      = 1'b0;
        flag_clr     = 1'b0;

        if (csb_rise) begin
            state_d    = S_IDLE;
            sdo_d      = 1'b0;
            sdo_oe_d   = 1'b0;
            reload_d   = 1'b0;
            pop_pend_d = 1'b0;
            flag_clr   = (state_q == S_CLR);
        end else if (state_q == S_IDLE) begin
            if (csb_fall) begin
                state_d    = S_CMD;
                mode_d     = mode;
                bit_cnt_d  = '0;
                tx_d       = '0;
                sdo_d      = 1'b0;
                sdo_oe_d   = 1'b1;
                reload_d   = 1'b0;
                pop_pend_d = 1'b0;
            end
        end else if (!csb_sync_q) begin
            if (sample_edge) begin
                // Words after the first are presented at the shift edge but popped here,
                // so a master that stops at a word boundary does not consume an extra entry.
                if (pop_pend_q) begin
                    pop_pend_d = 1'b0;
                    if (peek_empty_q) unf_set = 1'b1;
                    else              pop     = 1'b1;
                end
                if (state_q == S_CMD) begin
                    cmd_d     = cmd_byte[6:0];
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(7)) begin
                        bit_cnt_d = '0;
                        case (cmd_byte)
                            8'h03: begin
                                state_d = S_READ;
                                if (empty) begin
                                    tx_d    = '0;
                                    unf_set = 1'b1;
                                end else begin
                                    tx_d = head;
                                    pop  = 1'b1;
                                end
                            end
                            8'h05: begin
                                state_d            = S_STAT;
                                tx_d               = '0;
                                tx_d[DATA_W-1 -: 8] = status;
                            end
                            8'h01:   state_d = S_CLR;
                            default: state_d = S_DUMMY;
                        endcase
                    end
                end else if (state_q == S_READ) begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        reload_d  = 1'b1;
                    end
                end
            end
            if (shift_edge) begin
                if (state_q == S_READ && reload_q) begin
                    reload_d     = 1'b0;
                    pop_pend_d   = 1'b1;
                    peek_empty_d = empty;
                    sdo_d        = empty ? 1'b0 : head[DATA_W-1];
                    tx_d         = empty ? '0 : {head[DATA_W-2:0], 1'b0};
                end else if (state_q == S_READ || state_q == S_STAT) begin
                    sdo_d = tx_q[DATA_W-1];
                    tx_d  = {tx_q[DATA_W-2:0], 1'b0};
                end else begin
                    sdo_d = 1'b0;
                end
            end
        end
    end

    always_comb begin
        push        = sample_valid && (!full || pop);
        ovf_set     = sample_valid && full && !pop;
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d     = level_q + LW'(push) - LW'(pop);
        overflow_d  = flag_clr ? 1'b0 : (overflow_q | ovf_set);
        underflow_d = flag_clr ? 1'b0 : (underflow_q | unf_set);
        irq_d       = (level_q >= LW'(IRQ_THRESH)) | overflow_q;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= S_IDLE;
            csb_meta_q   <= 1'b0;
            csb_sync_q   <= 1'b0;
            csb_prev_q   <= 1'b0;
            sck_meta_q   <= 1'b0;
            sck_sync_q   <= 1'b0;
            sck_prev_q   <= 1'b0;
            sdi_meta_q   <= 1'b0;
            sdi_sync_q   <= 1'b0;
            mode_q       <= '0;
            bit_cnt_q    <= '0;
            cmd_q        <= '0;
            tx_q         <= '0;
            sdo_q        <= 1'b0;
            sdo_oe_q     <= 1'b0;
            reload_q     <= 1'b0;
            pop_pend_q   <= 1'b0;
            peek_empty_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            csb_meta_q   <= csb_meta_d;
            csb_sync_q   <= csb_sync_d;
            csb_prev_q   <= csb_prev_d;
            sck_meta_q   <= sck_meta_d;
            sck_sync_q   <= sck_sync_d;
            sck_prev_q   <= sck_prev_d;
            sdi_meta_q   <= sdi_meta_d;
            sdi_sync_q   <= sdi_sync_d;
            mode_q       <= mode_d;
            bit_cnt_q    <= bit_cnt_d;
            cmd_q        <= cmd_d;
            tx_q         <= tx_d;
            sdo_q        <= sdo_d;
            sdo_oe_q     <= sdo_oe_d;
            reload_q     <= reload_d;
            pop_pend_q   <= pop_pend_d;
            peek_empty_q <= peek_empty_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            irq_q        <= irq_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= sample_data;
    end

    assign sample_ready = !full;
    assign spi_sdo      = sdo_q;
    assign spi_sdo_oe   = sdo_oe_q;
    assign level        = level_q;
    assign irq          = irq_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_spi_sample_slave.sv
// Bench for spi_sample_slave: an SPI master task feeds received words to a scoreboard
// monitor; status outputs are compared against hand-computed values.
module tb_spi_sample_slave;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int LW     = 4;
    localparam int HALF   = 8;

    logic              clock = 1'b0;
    logic              resetb = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample_data = '0;
    logic              sample_ready;
    logic              spi_csb = 1'b1;
    logic              spi_sck = 1'b0;
    logic              spi_sdi = 1'b0;
    logic              spi_sdo;
    logic              spi_sdo_oe;
    logic [LW-1:0]     level;
    logic              irq, overflow, underflow;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    event        lead8_ev;

    always #5 clock = ~clock;

    spi_sample_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IRQ_THRESH(4)) dut (
        .clock(clock), .resetb(resetb), .mode(mode),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .level(level), .irq(irq), .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick(1);
        sample_valid = 1'b0;
    endtask

    // Master transaction: 8 command bits then nbits data bits; every wbits received bits form a word.
    task automatic xfer(input logic [1:0] m, input logic [7:0] cmd, input int nbits,
                        input int wbits, input bit toggle, input bit keep_sel);
        logic        cpol, cpha, rb, outbit, cmdsdo, oe_seen;
        logic [31:0] word;
        int          wcnt;
        cpol = m[1];
        cpha = m[0];
        mode = m;
        spi_sck = cpol;
        tick(4);
        spi_csb = 1'b0;
        tick(4);
        word = '0; wcnt = 0; cmdsdo = 1'b0; oe_seen = spi_sdo_oe;
        for (int i = 0; i < 8 + nbits; i++) begin
            outbit = 1'b0;
            if (i < 8) outbit = cmd[7-i];
            if (!cpha) begin
                spi_sdi = outbit;
                tick(HALF);
                rb = spi_sdo;
                spi_sck = ~cpol;
                if (i == 7) -> lead8_ev;
                tick(HALF);
                spi_sck = cpol;
            end else begin
                spi_sck = ~cpol;
                spi_sdi = outbit;
                tick(HALF);
                rb = spi_sdo;
                spi_sck = cpol;
                if (i == 7) -> lead8_ev;
                tick(HALF);
            end
            if (i < 8) cmdsdo |= rb;
            else begin
                word = {word[30:0], rb};
                wcnt++;
                if (wcnt == wbits) begin
                    obs_q.push_back(word);
                    word = '0;
                    wcnt = 0;
                end
            end
            if (toggle && i == 10) mode = ~m;
        end
        chk("sdo_oe_selected", {31'b0, oe_seen}, 32'd1);
        chk("sdo_during_cmd", {31'b0, cmdsdo}, 32'd0);
        if (!keep_sel) begin
            tick(HALF);
            spi_csb = 1'b1;
            tick(6);
            chk("sdo_oe_deselected", {31'b0, spi_sdo_oe}, 32'd0);
        end
    endtask

    // Scoreboard monitor: compares every word the master received against the expectation queue.
    initial begin
        logic [31:0] o_w, e_w;
        forever begin
            @(negedge clock);
            while (obs_q.size() > 0) begin
                o_w = obs_q.pop_front();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL spi_word: got 0x%0h expected no word", o_w);
                end else begin
                    e_w = exp_q.pop_front();
                    if (o_w !== e_w) begin
                        n_errors++;
                        $display("FAIL spi_word: got 0x%0h expected 0x%0h", o_w, e_w);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        chk("rst_level", 32'(level), 0);
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_overflow", {31'b0, overflow}, 0);
        chk("rst_underflow", {31'b0, underflow}, 0);
        chk("rst_sdo", {31'b0, spi_sdo}, 0);
        chk("rst_sdo_oe", {31'b0, spi_sdo_oe}, 0);
        resetb = 1'b1;
        tick(4);
        chk("rst_ready", {31'b0, sample_ready}, 1);

        // Mode 0 read of two words
        push(16'hA5A5);
        push(16'h1234);
        chk("m0_level_before", 32'(level), 2);
        exp_q.push_back(32'hA5A5);
        exp_q.push_back(32'h1234);
        xfer(2'd0, 8'h03, 32, 16, 1'b0, 1'b0);
        chk("m0_level_after", 32'(level), 0);
        chk("m0_underflow", {31'b0, underflow}, 0);

        // Threshold and overflow
        for (int k = 1; k <= 3; k++) push(DATA_W'(16'h0100 + k));
        tick(1);
        chk("thr_level3", 32'(level), 3);
        chk("thr_irq_at3", {31'b0, irq}, 0);
        push(16'h0104);
        chk("thr_level4", 32'(level), 4);
        chk("thr_irq_lag", {31'b0, irq}, 0);
        tick(1);
        chk("thr_irq_at4", {31'b0, irq}, 1);
        for (int k = 5; k <= 8; k++) push(DATA_W'(16'h0100 + k));
        chk("full_level", 32'(level), 8);
        chk("full_ready", {31'b0, sample_ready}, 0);
        chk("full_no_ovf", {31'b0, overflow}, 0);
        push(16'h0109);
        chk("ovf_set", {31'b0, overflow}, 1);
        chk("ovf_level", 32'(level), 8);
        for (int k = 1; k <= 8; k++) exp_q.push_back(32'h0100 + k);
        xfer(2'd0, 8'h03, 128, 16, 1'b0, 1'b0);
        chk("drain_level", 32'(level), 0);
        chk("drain_underflow", {31'b0, underflow}, 0);
        chk("drain_irq_ovf", {31'b0, irq}, 1);

        // Empty read, status, clear
        exp_q.push_back(32'h0000);
        xfer(2'd0, 8'h03, 16, 16, 1'b0, 1'b0);
        chk("empty_underflow", {31'b0, underflow}, 1);
        chk("empty_level", 32'(level), 0);
        exp_q.push_back(32'hE0);
        xfer(2'd0, 8'h05, 8, 8, 1'b0, 1'b0);
        xfer(2'd0, 8'h01, 0, 16, 1'b0, 1'b0);
        chk("clr_underflow", {31'b0, underflow}, 0);
        chk("clr_overflow", {31'b0, overflow}, 0);
        chk("clr_irq", {31'b0, irq}, 0);

        // Modes 1..3, with a mid-transaction mode toggle in modes 2 and 3
        for (int m = 1; m <= 3; m++) begin
            push(16'hA5A5);
            exp_q.push_back(32'hA5A5);
            xfer(2'(m), 8'h03, 16, 16, m >= 2, 1'b0);
            chk("mode_level", 32'(level), 0);
        end
        chk("mode_underflow", {31'b0, underflow}, 0);

        // Abort after 5 data bits
        push(16'h1111);
        push(16'h2222);
        xfer(2'd0, 8'h03, 5, 16, 1'b0, 1'b0);
        chk("abort_level", 32'(level), 1);
        exp_q.push_back(32'h2222);
        xfer(2'd0, 8'h03, 16, 16, 1'b0, 1'b0);
        chk("abort_next_level", 32'(level), 0);
        chk("abort_underflow", {31'b0, underflow}, 0);

        // Push in the same cycle as the entry pop while full
        for (int k = 0; k < 8; k++) push(DATA_W'(16'h3000 + k));
        chk("sim_full", 32'(level), 8);
        exp_q.push_back(32'h3000);
        fork
            xfer(2'd0, 8'h03, 16, 16, 1'b0, 1'b0);
            begin
                @(lead8_ev);
                tick(2);
                sample_valid = 1'b1;
                sample_data  = 16'h3333;
                tick(1);
                sample_valid = 1'b0;
            end
        join
        chk("sim_level", 32'(level), 8);
        chk("sim_no_ovf", {31'b0, overflow}, 0);
        for (int k = 1; k < 8; k++) exp_q.push_back(32'h3000 + k);
        exp_q.push_back(32'h3333);
        xfer(2'd0, 8'h03, 128, 16, 1'b0, 1'b0);
        chk("sim_drain_level", 32'(level), 0);

        // Reset in the middle of a READ
        push(16'hBEEF);
        push(16'hCAFE);
        xfer(2'd0, 8'h03, 6, 16, 1'b0, 1'b1);
        resetb = 1'b0;
        tick(1);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_sdo", {31'b0, spi_sdo}, 0);
        chk("midrst_sdo_oe", {31'b0, spi_sdo_oe}, 0);
        chk("midrst_irq", {31'b0, irq}, 0);
        spi_csb = 1'b1;
        spi_sck = 1'b0;
        tick(2);
        resetb = 1'b1;
        tick(4);
        exp_q.push_back(32'h00);
        xfer(2'd0, 8'h05, 8, 8, 1'b0, 1'b0);

        tick(20);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
